// File: rtl/wb_trace_checker.sv
// rtl/wb_trace_checker.sv - checks retired CPU register writes against a streamed golden trace
`timescale 1ns/1ps
module wb_trace_checker #(
  parameter int          DEPTH  = 8,
  parameter logic [31:0] END_PC = 32'hbfc00100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] debug_wb_pc,
  input  logic [3:0]  debug_wb_rf_wen,
  input  logic [4:0]  debug_wb_rf_wnum,
  input  logic [31:0] debug_wb_rf_wdata,
  input  logic        ref_valid,
  output logic        ref_ready,
  input  logic [31:0] ref_pc,
  input  logic [4:0]  ref_wnum,
  input  logic [31:0] ref_wdata,
  output logic        err,
  output logic        overflow,
  output logic [31:0] err_pc,
  output logic [31:0] err_exp_wdata,
  output logic [31:0] err_got_wdata,
  output logic [31:0] pass_cnt,
  output logic        done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_ERROR,
    ST_DONE
  } state_t;

  state_t state;
  logic   end_seen;

  // Trace FIFO storage; the masked data and its byte mask travel together
  logic [31:0] mem_pc    [DEPTH];
  logic [4:0]  mem_wnum  [DEPTH];
  logic [31:0] mem_wdata [DEPTH];
  logic [31:0] mem_mask  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [31:0] wb_mask;
  logic        capture;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        push_ok;
  logic        drop;
  logic        entry_match;
  logic        mismatch;
  logic        go_done;

  logic [31:0] head_pc;
  logic [4:0]  head_wnum;
  logic [31:0] head_wdata;
  logic [31:0] head_mask;

  assign wb_mask = {{8{debug_wb_rf_wen[3]}}, {8{debug_wb_rf_wen[2]}},
                    {8{debug_wb_rf_wen[1]}}, {8{debug_wb_rf_wen[0]}}};

  // Writes to r0 or with no enabled byte never change architectural state, so skip them
  assign capture = (|debug_wb_rf_wen) && (debug_wb_rf_wnum != 5'd0) && (state == ST_RUN);

  // Extra pointer MSB distinguishes full from empty when the index bits coincide
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign ref_ready = (state == ST_RUN) && !fifo_empty;
  assign pop       = ref_valid && ref_ready;

  // A simultaneous pop frees a slot, so a push into a full FIFO is legal then
  assign push_ok = capture && (!fifo_full || pop);
  assign drop    = capture && fifo_full && !pop;

  assign head_pc    = mem_pc[rd_ptr[AW-1:0]];
  assign head_wnum  = mem_wnum[rd_ptr[AW-1:0]];
  assign head_wdata = mem_wdata[rd_ptr[AW-1:0]];
  assign head_mask  = mem_mask[rd_ptr[AW-1:0]];

  // Golden data is compared only on the bytes the CPU actually wrote
  assign entry_match = (head_pc == ref_pc) && (head_wnum == ref_wnum) &&
                       (head_wdata == (ref_wdata & head_mask));
  assign mismatch    = pop && !entry_match;

  // Completion needs the trace fully drained with nothing arriving this cycle
  assign go_done = end_seen && fifo_empty && !capture;

  // FIFO storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_pc[wr_ptr[AW-1:0]]    <= debug_wb_pc;
      mem_wnum[wr_ptr[AW-1:0]]  <= debug_wb_rf_wnum;
      mem_wdata[wr_ptr[AW-1:0]] <= debug_wb_rf_wdata & wb_mask;
      mem_mask[wr_ptr[AW-1:0]]  <= wb_mask;
    end
  end

  // FIFO pointer advance on accepted push and on golden handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Checker FSM with its registered status outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_RUN;
      end_seen      <= 1'b0;
      err           <= 1'b0;
      overflow      <= 1'b0;
      err_pc        <= 32'd0;
      err_exp_wdata <= 32'd0;
      err_got_wdata <= 32'd0;
      pass_cnt      <= 32'd0;
      done          <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (debug_wb_pc == END_PC) begin
            end_seen <= 1'b1;
          end
          if (pop && entry_match && (pass_cnt != 32'hffffffff)) begin
            pass_cnt <= pass_cnt + 32'd1;
          end
          if (drop) begin
            overflow <= 1'b1;
          end
          if (mismatch) begin
            err           <= 1'b1;
            err_pc        <= head_pc;
            err_exp_wdata <= ref_wdata;
            err_got_wdata <= head_wdata;
            state         <= ST_ERROR;
          end else if (drop) begin
            err    <= 1'b1;
            err_pc <= debug_wb_pc;
            state  <= ST_ERROR;
          end else if (go_done) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_ERROR;
        end
      endcase
    end
  end

endmodule
